// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; byte out ~2+HALF+9*CPP cycles after the start edge, with a 1-cycle valid pulse.
// No backpressure: the consumer must capture data on valid; data then holds until the next good frame.
module uart_rx #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPP  = clock_frequency / baud_rate;
  localparam int HALF = CPP / 2;
  localparam logic [15:0] CPP_M1  = 16'(CPP - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, frame_err_nxt;
  logic        tick;

  assign tick = (cnt == 16'd0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt - 16'd1;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = HALF_M1;
          state_nxt = START;
        end
      end
      START: begin
        // Mid start bit: a line that has gone high again was only a glitch
        if (tick) begin
          if (!rx_s) begin
            cnt_nxt     = CPP_M1;
            bit_cnt_nxt = 3'd0;
            state_nxt   = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt = {rx_s, shreg[7:1]};
          cnt_nxt   = CPP_M1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line is released so a break cannot retrigger
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame stimulus for uart_rx, checked every cycle against a queue of expected
// receive events derived from the frame timing rules, plus literal checks on directed cases.
module tb_uart_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPP    = CLK_HZ / BAUD;
  localparam int HALF   = CPP / 2;
  localparam int TOL    = 2;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .clock_frequency(CLK_HZ),
    .baud_rate      (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    bit         is_err;
    logic [7:0] b;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         n_vld = 0;
  int         n_ferr = 0;
  int         last_vld_cyc = 0;
  logic [7:0] last_vld_dat = 8'h00;
  logic [7:0] last_good = 8'h00;
  bit         mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_line(input string name, input int act, input int req);
    tests++;
    fails++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Compare process: every pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (valid || frame_err) begin
        if (valid) begin
          n_vld++;
          last_vld_cyc = cyc;
          last_vld_dat = data;
        end
        if (frame_err) n_ferr++;
        if (expq.size() == 0) begin
          fail_line("unexpected_pulse", cyc, -1);
        end else begin
          e = expq.pop_front();
          chk("pulse_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("pulse_cycle", 32'(cyc), ((cyc >= e.t - TOL) && (cyc <= e.t + TOL)) ? 32'(cyc) : 32'(e.t));
          if (valid) begin
            chk("valid_data", {24'd0, data}, {24'd0, e.b});
            last_good = e.b;
          end else begin
            chk("ferr_data_held", {24'd0, data}, {24'd0, last_good});
          end
        end
      end else if (expq.size() != 0 && cyc > expq[0].t + TOL) begin
        fail_line("missing_pulse", cyc, expq[0].t);
        void'(expq.pop_front());
      end else if (expq.size() == 0 || cyc < expq[0].t - TOL) begin
        chk("data_held", {24'd0, data}, {24'd0, last_good});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; a low stop bit is left low on return
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t x;
    x.t      = cyc + 3 + HALF + 9 * CPP;
    x.is_err = !stop_ok;
    x.b      = b;
    expq.push_back(x);
    rx = 1'b0;
    tick(CPP);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPP);
    end
    chk("busy_before_stop", {31'd0, busy}, 32'd1);
    rx = stop_ok;
    tick(CPP);
  endtask

  task automatic wait_not_busy(input string name, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  int         t0;
  int         v0;
  int         f0;
  logic [7:0] rb;
  logic [7:0] abort_b;
  bit         drained;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    tick(4);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst    = 1'b0;
    mon_en = 1;
    tick(5);

    // Single byte
    v0 = n_vld;
    t0 = cyc;
    send_frame(8'hA5, 1);
    tick(6);
    chk("a5_count", 32'(n_vld - v0), 32'd1);
    chk("a5_data", {24'd0, last_vld_dat}, 32'hA5);
    chk("a5_latency_ok", {31'd0, (last_vld_cyc - t0 >= 95) && (last_vld_cyc - t0 <= 100)}, 32'd1);

    // Back-to-back, no idle gap
    v0 = n_vld;
    f0 = n_ferr;
    send_frame(8'h00, 1);
    send_frame(8'hFF, 1);
    send_frame(8'h5A, 1);
    tick(6);
    chk("b2b_count", 32'(n_vld - v0), 32'd3);
    chk("b2b_last", {24'd0, last_vld_dat}, 32'h5A);
    chk("b2b_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Start glitch
    v0 = n_vld;
    f0 = n_ferr;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    chk("glitch_busy_rises", {31'd0, busy}, 32'd1);
    wait_not_busy("glitch_busy_clears", 8);
    tick(4);
    chk("glitch_no_pulse", 32'(n_vld - v0 + n_ferr - f0), 32'd0);
    send_frame(8'h3C, 1);
    tick(4);
    chk("after_glitch_data", {24'd0, data}, 32'h3C);

    // Framing error with line held low afterwards
    v0 = n_vld;
    f0 = n_ferr;
    send_frame(8'h81, 0);
    tick(29);
    chk("ferr_busy_held", {31'd0, busy}, 32'd1);
    tick(1);
    rx = 1'b1;
    wait_not_busy("ferr_busy_clears", 6);
    tick(2);
    chk("ferr_count", 32'(n_ferr - f0), 32'd1);
    chk("ferr_no_valid", 32'(n_vld - v0), 32'd0);
    chk("ferr_data_kept", {24'd0, data}, 32'h3C);
    send_frame(8'h42, 1);
    tick(4);
    chk("after_ferr_data", {24'd0, data}, 32'h42);

    // Reset during data bit 4; the upper bits are all ones so the tail cannot look like a start edge
    abort_b = 8'hF3;
    v0 = n_vld;
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 4; i++) begin
      rx = abort_b[i];
      tick(CPP);
    end
    rx = abort_b[4];
    tick(HALF);
    rst = 1'b1;
    expq.delete();
    last_good = 8'h00;
    tick(1);
    rst = 1'b0;
    chk("midrst_data", {24'd0, data}, 32'h00);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick(CPP - HALF - 1);
    for (int i = 5; i < 8; i++) begin
      rx = abort_b[i];
      tick(CPP);
    end
    rx = 1'b1;
    tick(CPP + 3);
    chk("midrst_no_valid", 32'(n_vld - v0), 32'd0);
    send_frame(8'hC3, 1);
    tick(4);
    chk("after_rst_data", {24'd0, data}, 32'hC3);

    // Random bytes, random gaps, occasional bad stop bit
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(rb, 0);
        tick($urandom_range(0, 15));
        rx = 1'b1;
        tick(4);
      end else begin
        send_frame(rb, 1);
        tick($urandom_range(0, 3));
      end
    end

    // 256 sequential bytes as a serialiser would send them
    v0 = n_vld;
    for (int n = 0; n < 256; n++) begin
      send_frame(8'(n), 1);
      tick($urandom_range(0, 2));
    end
    tick(6);
    chk("seq_count", 32'(n_vld - v0), 32'd256);
    chk("seq_last", {24'd0, last_vld_dat}, 32'hFF);

    drained = 0;
    for (int i = 0; i < 300; i++) begin
      if (expq.size() == 0) begin
        drained = 1;
        break;
      end
      tick(1);
    end
    chk("queue_drained", {31'd0, drained}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
